// File: rtl/apb_pkg.sv
// Shared types and constants for the APB requester and its memory slave.
package apb_pkg;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 8;
    localparam int APB_MEM_DEPTH = 16;

    // Bridge transfer phases
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // One byte-wide command as presented on the command port
    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    // Completion status returned on the response port
    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state watchdog: counts ACCESS cycles with pready low and flags the
// cycle on which the count would reach TIMEOUT.
module apb_wait_timer
#(
    parameter int TIMEOUT = 16
)
(
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] r_cnt;
    logic [8:0] w_cnt_next;

    // Saturating wait counter; cleared when a new transfer starts
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Expiry fires on the wait edge whose increment lands on TIMEOUT, so the
    // FSM leaves ACCESS exactly TIMEOUT cycles after entering it.
    assign w_cnt_next = {1'b0, r_cnt} + 9'd1;
    assign expired    = enable && (w_cnt_next >= 9'(TIMEOUT));

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: turns valid/ready byte commands into APB SETUP/ACCESS
// transfers and returns data/status on a valid/ready response port.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
)
(
    input  logic              pclk,
    input  logic              presetn,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_e        r_state;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;
    logic              r_rsp_timeout;

    logic              w_accept;
    logic              w_wait;
    logic              w_expired;

    assign w_accept = (r_state == IDLE) && cmd_valid;
    // pready low in ACCESS is a wait state; pready high always wins over expiry
    assign w_wait   = (r_state == ACCESS) && !pready;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (w_accept),
        .enable  (w_wait),
        .expired (w_expired)
    );

    // Transfer FSM with registered APB and response outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= IDLE;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_pwrite <= cmd_write;
                        r_paddr  <= cmd_addr;
                        r_pwdata <= cmd_wdata;
                        r_psel   <= 1'b1;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= pslverr;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_rdata   <= (!r_pwrite && !pslverr) ? prdata : '0;
                        r_state       <= RESP;
                    end else if (w_expired) begin
                        r_psel        <= 1'b0;
                        r_penable     <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_rdata   <= '0;
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_rsp_timeout <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = (r_state == IDLE);
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: 16 x 8-bit APB memory slave with programmable
// wait states, a directed vector table, reset corner case and random traffic.
module tb_apb_master_bridge;
    import apb_pkg::*;

    localparam int TMO = 4;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel, penable, pwrite;
    logic [31:0] paddr;
    logic [7:0]  pwdata;
    logic [7:0]  prdata;
    logic        pready;
    logic        pslverr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    // ---------------- APB memory slave ----------------
    int         slv_wait = 0;
    logic       slv_stall = 1'b0;
    int         acc_cnt = 0;
    logic [7:0] mem [APB_MEM_DEPTH] = '{default: 8'h00};

    assign pready  = psel && penable && !slv_stall && (acc_cnt >= slv_wait);
    assign pslverr = psel && penable && pready && (paddr >= 32'(APB_MEM_DEPTH));
    assign prdata  = (paddr < 32'(APB_MEM_DEPTH)) ? mem[paddr[3:0]] : 8'hEE;

    always @(posedge pclk) begin
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (psel && penable && pready && pwrite && (paddr < 32'(APB_MEM_DEPTH)))
            mem[paddr[3:0]] <= pwdata;
    end

    // ---------------- APB protocol monitor ----------------
    logic prev_psel = 1'b0;
    logic proto_bad = 1'b0;
    always @(negedge pclk) begin
        if (penable && !psel) proto_bad <= 1'b1;
        if (psel && !prev_psel && penable) proto_bad <= 1'b1;
        prev_psel <= psel;
    end

    // ---------------- reference model ----------------
    logic [7:0] mdl [APB_MEM_DEPTH] = '{default: 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One complete transfer; waits < 0 makes the slave never ready
    task automatic run_txn(input string tag, input logic w, input logic [31:0] a,
                           input logic [7:0] d, input int waits, input int hold,
                           input logic [7:0] e_rd, input logic e_err, input logic e_tmo,
                           input int e_lat);
        int n;
        int lat;
        int pc;
        slv_wait  = (waits < 0) ? 0 : waits;
        slv_stall = (waits < 0);
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk({tag, " accept"}, 32'(n < 50), 32'd1);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        chk({tag, " setup_psel"}, 32'(psel), 32'd1);
        chk({tag, " setup_penable"}, 32'(penable), 32'd0);
        chk({tag, " paddr"}, paddr, a);
        chk({tag, " pwrite"}, 32'(pwrite), 32'(w));
        if (w) chk({tag, " pwdata"}, 32'(pwdata), 32'(d));
        pc = 1;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge pclk); #1;
            lat++;
            if (psel) pc++;
        end
        chk({tag, " latency"}, lat, e_lat);
        chk({tag, " psel_cycles"}, pc, e_lat);
        chk({tag, " rdata"}, 32'(rsp_rdata), 32'(e_rd));
        chk({tag, " err"}, 32'(rsp_err), 32'(e_err));
        chk({tag, " timeout"}, 32'(rsp_timeout), 32'(e_tmo));
        chk({tag, " resp_psel"}, 32'({psel, penable}), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge pclk);
            cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd1;
            @(posedge pclk); #1;
            chk({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold_rdata"}, 32'(rsp_rdata), 32'(e_rd));
            chk({tag, " hold_cmd_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, " hold_psel"}, 32'(psel), 32'd0);
        end
        @(negedge pclk);
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        slv_stall = 1'b0;
        chk({tag, " release_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " release_timeout"}, 32'(rsp_timeout), 32'd0);
        chk({tag, " release_cmd_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [7:0]  wdata;
        int          waits;
        int          hold;
        logic [7:0]  e_rd;
        logic        e_err;
        logic        e_tmo;
        int          e_lat;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic       w;
        logic [31:0] a;
        logic [7:0] d;
        logic [7:0] e_rd;
        logic       e_err;
        int         wt;
        int         hd;

        //           w     addr    wdata  wait hold rdata  err  tmo  lat
        tbl[0]  = '{1'b1, 32'd3,  8'h5A,  0,   0, 8'h00, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 32'd3,  8'h00,  0,   0, 8'h5A, 1'b0, 1'b0, 2};
        tbl[2]  = '{1'b1, 32'h20, 8'hA5,  0,   0, 8'h00, 1'b1, 1'b0, 2};
        tbl[3]  = '{1'b0, 32'd16, 8'h00,  0,   0, 8'h00, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b1, 32'd7,  8'hC3,  1,   0, 8'h00, 1'b0, 1'b0, 3};
        tbl[5]  = '{1'b0, 32'd7,  8'h00,  0,   5, 8'hC3, 1'b0, 1'b0, 2};
        tbl[6]  = '{1'b1, 32'd15, 8'hFF,  3,   0, 8'h00, 1'b0, 1'b0, 5};
        tbl[7]  = '{1'b0, 32'd15, 8'h00,  2,   1, 8'hFF, 1'b0, 1'b0, 4};
        tbl[8]  = '{1'b0, 32'd4,  8'h00, -1,   0, 8'h00, 1'b1, 1'b1, 1 + TMO};
        tbl[9]  = '{1'b1, 32'd0,  8'h11, -1,   2, 8'h00, 1'b1, 1'b1, 1 + TMO};
        tbl[10] = '{1'b0, 32'd0,  8'h00,  0,   0, 8'h00, 1'b0, 1'b0, 2};

        // Reset state, checked while reset is asserted and before any edge
        #1;
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", 32'(pwdata), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        repeat (2) @(negedge pclk);
        presetn = 1'b1;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].wdata,
                    tbl[i].waits, tbl[i].hold, tbl[i].e_rd, tbl[i].e_err,
                    tbl[i].e_tmo, tbl[i].e_lat);
            if (tbl[i].w && !tbl[i].e_err) mdl[tbl[i].addr[3:0]] = tbl[i].wdata;
        end

        // Asynchronous reset in the middle of a stalled ACCESS
        slv_stall = 1'b1;
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd3;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        chk("arst_in_access", 32'({psel, penable}), 32'd3);
        #2;
        presetn = 1'b0;
        #1;
        chk("arst_psel", 32'(psel), 32'd0);
        chk("arst_penable", 32'(penable), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge pclk);
        presetn = 1'b1;
        slv_stall = 1'b0;
        run_txn("post_reset", 1'b0, 32'd3, 8'h00, 0, 0, 8'h5A, 1'b0, 1'b0, 2);

        // Random traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            w  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, APB_MEM_DEPTH + 3));
            d  = 8'($urandom);
            wt = int'($urandom_range(0, TMO - 1));
            hd = int'($urandom_range(0, 2));
            e_err = (a >= 32'(APB_MEM_DEPTH));
            e_rd  = (!w && !e_err) ? mdl[a[3:0]] : 8'h00;
            run_txn($sformatf("rnd%0d", i), w, a, d, wt, hd, e_rd, e_err, 1'b0, 2 + wt);
            if (w && !e_err) mdl[a[3:0]] = d;
        end

        chk("apb_protocol", 32'(proto_bad), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB requester that drives the single-slave APB bus in front of the 16 x 8-bit APB memory slave. It takes byte-wide read/write commands from a valid/ready command port, runs each one as a standard APB SETUP/ACCESS transfer, and returns read data and error status on a valid/ready response port. A programmable wait-state watchdog ends any transfer whose slave never raises `pready`.

## Interface
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 8: APB data width.
- `TIMEOUT`, 16: maximum number of ACCESS cycles with `pready` low before abort; legal range 1..255.

Ports:
- `pclk` in 1: bus clock; all logic on its rising edge.
- `presetn` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out DATA_W: read data; 0 for writes and for errored transfers.
- `rsp_err` out 1: `pslverr` was sampled high, or the transfer timed out.
- `rsp_timeout` out 1: the transfer was aborted by the watchdog.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W, `pwdata` out DATA_W: APB address and write data.
- `prdata` in DATA_W, `pready` in 1, `pslverr` in 1: APB slave return.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - `cmd_ready`=1 only in IDLE.
  - On `cmd_valid`: register `cmd_write`/`cmd_addr`/`cmd_wdata` into `pwrite`/`paddr`/`pwdata`, then go to SETUP.
- SETUP: `psel`=1, `penable`=0. Go to ACCESS unconditionally.
- ACCESS: `psel`=1, `penable`=1. `paddr`/`pwrite`/`pwdata` held stable.
  - `pready`=1 at an edge: go to RESP. Capture `rsp_err`=`pslverr`. Capture `rsp_rdata`=`prdata` only for a read with `pslverr`=0; otherwise `rsp_rdata`=0.
  - `pready`=0: increment the wait counter. When the counter reaches TIMEOUT, go to RESP with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0.
- RESP:
  - `psel`=`penable`=0, `rsp_valid`=1.
  - Response fields are held stable until `rsp_ready`=1, then go to IDLE and clear `rsp_timeout`.
- `pready`, `pslverr` and `prdata` are ignored outside ACCESS.
- Wait counter: 8-bit; cleared on entry to SETUP; saturates and never wraps.
- `pslverr` and timeout at the same edge cannot occur: `pready` high always wins, and the timeout is not flagged.
- Reset mid-transfer: bus is dropped immediately to idle (`psel`=`penable`=0). No response is generated for the aborted command.

## Timing
- Reset values: `psel`=`penable`=`pwrite`=0, `paddr`=0, `pwdata`=0, `cmd_ready`=1 (state IDLE), `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0, wait counter 0.
- All APB outputs and response outputs are registered. `cmd_ready` is decoded from state only and never depends on `cmd_valid`.
- Zero-wait slave, command accepted at edge E:
  - SETUP in cycle E+1.
  - ACCESS in E+2.
  - `rsp_valid` high after edge E+2.
  - With `rsp_ready`=1, IDLE after E+3; next accept at E+4.
  - Throughput: 4 cycles per transfer.
- Each slave wait state adds 1 cycle.
- Timeout: `rsp_valid` rises TIMEOUT cycles after entering ACCESS.
- The APB protocol rule holds: `penable` is never high without `psel`, and is never high in the first cycle of `psel`.

## Structure
- Shared package `apb_pkg`:
  - `apb_state_e` enum (IDLE, SETUP, ACCESS, RESP).
  - Localparams `APB_ADDR_W`=32, `APB_DATA_W`=8, `APB_MEM_DEPTH`=16.
  - The packed command struct (write, addr, wdata) and the packed response struct (rdata, err, timeout).
- One sub-module, `apb_wait_timer`: ports clear, enable, TIMEOUT parameter, expired output.
- `apb_master_bridge` is the top. It instantiates `apb_wait_timer` and connects point-to-point to the APB memory slave in the bench.

## Test plan
- Write then read: write 0x5A to address 3, then read address 3.
  - Required: `rsp_err`=0 on both, `rsp_rdata`=0x5A on the read.
  - Required: `psel` high 2 cycles per transfer.
- Out-of-range write to address 0x20: slave asserts `pslverr` → `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- Out-of-range read from address 16 → `rsp_err`=1, `rsp_rdata`=0x00.
- Slave model holds `pready`=0 with TIMEOUT=4:
  - Required: `rsp_valid` rises 4 cycles after ACCESS entry, with `rsp_timeout`=1 and `rsp_err`=1.
  - Required: `psel`=0 in RESP.
- `rsp_ready`=0 for 5 cycles after a read of 0xC3: `rsp_valid` and `rsp_rdata`=0xC3 are held stable, `cmd_ready`=0 throughout, and a pending `cmd_valid` is not accepted.
- Async reset during ACCESS: `psel`/`penable` go to 0 without waiting for a clock edge, `rsp_valid`=0, and the next command after reset completes normally.
